// File: rtl/iic_init_seq.sv
// -----------------------------------------------------------------------------
// iic_init_seq
//   Boot-time register loader for the I2C master. After a start pulse it waits
//   PWRUP_CYCLES, then walks an external (reg_addr, reg_data) table. Each entry
//   becomes one write on the master's wr_req/wr_fin handshake. An entry whose
//   address is 8'hFF is a delay of tbl_data * DELAY_UNIT cycles. A failed write
//   (nack, timeout, or verify miss) is retried up to RETRY_MAX times. After that
//   the sequencer stops in ERROR and reports the failing index.
//
//   Optional feature macro: IIC_VERIFY_EN
//     Defined: each acked write is read back and compared.
//     Undefined: rd_req and rd_addr stay 0, and the rd_* inputs are unused.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               pulse; accepted only in IDLE, DONE or ERROR
//   tbl_idx             table index; tbl_addr/tbl_data return combinationally
//   tbl_addr, tbl_data  entry contents (tbl_addr 8'hFF = delay entry)
//   wr_req/addr/data    write request to master (registered, held until wr_fin)
//   wr_fin, wr_ack      write-done pulse and ack, valid together
//   rd_req, rd_addr     read-back request (verify build only)
//   rd_data/fin/ack     read-back result, valid with rd_fin
//   busy, done, error   status levels; err_idx = failing entry while error
//   state_dbg           current FSM state, for checkers
//
// Handshake: a req is raised by the sequencer and held until the matching fin
// pulse or until TIMEOUT_CYCLES elapse. It is dropped by the clock edge that
// samples fin, and it is never raised again in the same cycle. The master
// therefore always sees req low between transactions. A fin that arrives
// while no req is outstanding is ignored.
// -----------------------------------------------------------------------------
module iic_init_seq #(
  parameter int NUM_ENTRIES    = 16,
  parameter int PWRUP_CYCLES   = 1_000_000,
  parameter int DELAY_UNIT     = 100_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int RETRY_MAX      = 3,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_addr,
  input  logic [7:0]       tbl_data,
  output logic             wr_req,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  input  logic             wr_fin,
  input  logic             wr_ack,
  output logic             rd_req,
  output logic [7:0]       rd_addr,
  input  logic [7:0]       rd_data,
  input  logic             rd_fin,
  input  logic             rd_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
  output logic [3:0]       state_dbg
);

  // One counter serves both the power-up wait and delay entries.
  localparam int DLY_MAX  = 255 * DELAY_UNIT;
  localparam int WAIT_MAX = (PWRUP_CYCLES > DLY_MAX) ? PWRUP_CYCLES : DLY_MAX;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W     = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PWRUP  = 4'd1,
    S_FETCH  = 4'd2,
    S_DELAY  = 4'd3,
    S_WRITE  = 4'd4,
    S_VERIFY = 4'd5,
    S_RETRY  = 4'd6,
    S_NEXT   = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [RC_W-1:0]   retry_cnt;
  logic [WAIT_W-1:0] dly_load;
  logic              to_hit;

  assign state_dbg = state;
  assign dly_load  = WAIT_W'(32'(tbl_data) * 32'(DELAY_UNIT));
  // The last permitted req cycle. A req stays high for exactly TIMEOUT_CYCLES cycles.
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifndef IIC_VERIFY_EN
  assign rd_req  = 1'b0;
  assign rd_addr = 8'h00;
  logic unused_rd;
  assign unused_rd = &{1'b0, rd_data, rd_fin, rd_ack};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tbl_idx   <= '0;
      err_idx   <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      retry_cnt <= '0;
`ifdef IIC_VERIFY_EN
      rd_req    <= 1'b0;
      rd_addr   <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_PWRUP;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
            tbl_idx   <= '0;
            retry_cnt <= '0;
            wait_cnt  <= WAIT_W'(PWRUP_CYCLES - 1);
          end
        end
        S_PWRUP: begin
          if (wait_cnt == '0) state <= S_FETCH;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_FETCH: begin
          if (tbl_addr == 8'hFF) begin
            wait_cnt <= dly_load;
            state    <= S_DELAY;
          end else begin
            wr_addr <= tbl_addr;
            wr_data <= tbl_data;
            wr_req  <= 1'b1;
            to_cnt  <= '0;
            state   <= S_WRITE;
          end
        end
        S_DELAY: begin
          // Delay entries cannot fail, so they never enter RETRY.
          if (wait_cnt == '0) state <= S_NEXT;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_WRITE: begin
          if (wr_fin) begin
            wr_req <= 1'b0;
            if (wr_ack) begin
`ifdef IIC_VERIFY_EN
              rd_req  <= 1'b1;
              rd_addr <= wr_addr;
              to_cnt  <= '0;
              state   <= S_VERIFY;
`else
              state   <= S_NEXT;
`endif
            end else begin
              state <= S_RETRY;
            end
          end else if (to_hit) begin
            wr_req <= 1'b0;
            state  <= S_RETRY;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef IIC_VERIFY_EN
        S_VERIFY: begin
          if (rd_fin) begin
            rd_req <= 1'b0;
            state  <= (rd_ack && (rd_data == wr_data)) ? S_NEXT : S_RETRY;
          end else if (to_hit) begin
            rd_req <= 1'b0;
            state  <= S_RETRY;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`endif
        S_RETRY: begin
          if (retry_cnt < RC_W'(RETRY_MAX)) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= S_FETCH;
          end else begin
            err_idx <= tbl_idx;
            error   <= 1'b1;
            busy    <= 1'b0;
            state   <= S_ERROR;
          end
        end
        S_NEXT: begin
          if (tbl_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            tbl_idx   <= tbl_idx + 1'b1;
            retry_cnt <= '0;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_init_seq.sv
// -----------------------------------------------------------------------------
// tb_iic_init_seq
//   Bench for iic_init_seq with a small configuration. A master model answers
//   every request 20 cycles after it is raised. How many times each table
//   entry fails is set per entry in the bench. A failure is either a nack or
//   no fin at all. The expected write sequence and the final status come from
//   a reference model of the table-walk rules.
// -----------------------------------------------------------------------------
module tb_iic_init_seq;

  localparam int N   = 4;
  localparam int PWR = 10;
  localparam int DU  = 5;
  localparam int TO  = 50;
  localparam int RM  = 2;
  localparam int LAT = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] tbl_idx, err_idx;
  logic [7:0] tbl_addr, tbl_data;
  logic       wr_req, wr_fin, wr_ack;
  logic [7:0] wr_addr, wr_data;
  logic       rd_req, rd_fin, rd_ack;
  logic [7:0] rd_addr, rd_data;
  logic       busy, done, error;
  logic [3:0] state_dbg;

  iic_init_seq #(
    .NUM_ENTRIES(N), .PWRUP_CYCLES(PWR), .DELAY_UNIT(DU),
    .TIMEOUT_CYCLES(TO), .RETRY_MAX(RM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_fin(wr_fin), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_fin(rd_fin), .rd_ack(rd_ack),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .state_dbg(state_dbg)
  );

  // ---------------- table ROM and per-entry failure plan ----------------
  logic [7:0] cur_a[N];
  logic [7:0] cur_d[N];
  int         cur_fail[N];   // write attempts that fail (1-based) per entry
  int         cur_vfail[N];  // read-backs that return corrupt data per entry
  bit         cur_no_fin;    // failing writes get no fin (timeout) instead of nack

  assign tbl_addr = cur_a[tbl_idx];
  assign tbl_data = cur_d[tbl_idx];

  // ---------------- master model + monitor (negedge) ----------------
  int         cyc = 0;
  int         attempts[N];
  logic [15:0] got_q[$];
  int         rise_q[$];
  int         len_q[$];
  bit         wr_prev = 0, w_pend = 0, w_fail = 0;
  int         w_cnt = 0;
  logic [7:0] last_wd = 8'h00;
  bit         rd_prev = 0, r_pend = 0;
  int         r_cnt = 0;

  initial begin
    wr_fin = 0; wr_ack = 0; rd_fin = 0; rd_ack = 0; rd_data = 8'h00;
    cur_no_fin = 0;
    for (int i = 0; i < N; i++) begin
      cur_a[i] = 8'h00; cur_d[i] = 8'h00; cur_fail[i] = 0; cur_vfail[i] = 0; attempts[i] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    wr_fin = 0; wr_ack = 0; rd_fin = 0; rd_ack = 0;
    if (!reset_n) begin
      w_pend = 0; r_pend = 0;
    end else begin
      if (wr_req && !wr_prev) begin
        got_q.push_back({wr_addr, wr_data});
        rise_q.push_back(cyc);
        attempts[tbl_idx]++;
        w_fail  = (attempts[tbl_idx] <= cur_fail[tbl_idx]);
        last_wd = wr_data;
        w_pend  = 1; w_cnt = 0;
      end
      if (w_pend && wr_req) begin
        w_cnt++;
        if (w_cnt == LAT) begin
          w_pend = 0;
          if (!(w_fail && cur_no_fin)) begin
            wr_fin = 1; wr_ack = !w_fail;
          end
        end
      end
`ifdef IIC_VERIFY_EN
      if (rd_req && !rd_prev) begin r_pend = 1; r_cnt = 0; end
      if (r_pend && rd_req) begin
        r_cnt++;
        if (r_cnt == LAT) begin
          r_pend = 0; rd_fin = 1; rd_ack = 1;
          rd_data = (attempts[tbl_idx] <= cur_vfail[tbl_idx]) ? last_wd - 8'd1 : last_wd;
        end
      end
`endif
    end
    if (!wr_req && wr_prev && rise_q.size() > 0) len_q.push_back(cyc - rise_q[$]);
    wr_prev = wr_req;
    rd_prev = rd_req;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  bit exp_done, exp_err;
  int exp_eidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Table-walk rules: delays issue nothing; a write entry is tried up to
  // RM+1 times, and running out of tries stops the walk with an error.
  task automatic model_run();
    bit ok;
    exp_q.delete();
    exp_done = 1; exp_err = 0; exp_eidx = 0;
    for (int i = 0; i < N; i++) begin
      if (cur_a[i] == 8'hFF) continue;
      ok = 0;
      for (int att = 1; att <= RM + 1 && !ok; att++) begin
        exp_q.push_back({cur_a[i], cur_d[i]});
        if (att > cur_fail[i] + cur_vfail[i]) ok = 1;
      end
      if (!ok) begin
        exp_done = 0; exp_err = 1; exp_eidx = i;
        return;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_seq(input string tag, input bit poke);
    int n;
    for (int i = 0; i < N; i++) attempts[i] = 0;
    got_q.delete(); rise_q.delete(); len_q.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (!(done || error) && n < 4000) begin
      @(negedge clk);
      n++;
      start = (poke && n == 60);  // extra start while busy must be ignored
    end
    start = 0;
    chk($sformatf("%s_finished_in_budget", tag), (n < 4000), 1);
  endtask

  task automatic compare_run(input string tag);
    chk($sformatf("%s_num_writes", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
    chk($sformatf("%s_done", tag), done, exp_done);
    chk($sformatf("%s_error", tag), error, exp_err);
    chk($sformatf("%s_err_idx", tag), err_idx, exp_eidx);
    chk($sformatf("%s_busy", tag), busy, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [N-1:0][7:0] a;      // element [i] = entry i
    logic [N-1:0][7:0] d;
    logic [N-1:0][1:0] fail;
    logic              no_fin;
    logic              exp_done;
    logic              exp_err;
    logic [1:0]        exp_eidx;
    logic [3:0]        exp_nw;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int g;
    // Packed concatenations list entry 3 first, entry 0 last.
    vecs[0] = '{a: {8'h10, 8'hFF, 8'h03, 8'h02}, d: {8'h80, 8'h04, 8'h22, 8'h11},
                fail: {2'd0, 2'd0, 2'd0, 2'd0}, no_fin: 0,
                exp_done: 1, exp_err: 0, exp_eidx: 0, exp_nw: 3};
    vecs[1] = '{a: {8'h10, 8'hFF, 8'h03, 8'h02}, d: {8'h80, 8'h04, 8'h22, 8'h11},
                fail: {2'd0, 2'd0, 2'd2, 2'd0}, no_fin: 0,
                exp_done: 1, exp_err: 0, exp_eidx: 0, exp_nw: 5};
    vecs[2] = '{a: {8'h10, 8'hFF, 8'h03, 8'h02}, d: {8'h80, 8'h04, 8'h22, 8'h11},
                fail: {2'd0, 2'd0, 2'd3, 2'd0}, no_fin: 0,
                exp_done: 0, exp_err: 1, exp_eidx: 1, exp_nw: 4};
    vecs[3] = '{a: {8'h10, 8'hFF, 8'h03, 8'h02}, d: {8'h80, 8'h04, 8'h22, 8'h11},
                fail: {2'd0, 2'd0, 2'd0, 2'd3}, no_fin: 1,
                exp_done: 0, exp_err: 1, exp_eidx: 0, exp_nw: 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_tbl_idx", tbl_idx, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_state", state_dbg, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    // T1..T4 from the vector table
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < N; j++) begin
        cur_a[j] = vecs[v].a[j]; cur_d[j] = vecs[v].d[j];
        cur_fail[j] = int'(vecs[v].fail[j]); cur_vfail[j] = 0;
      end
      cur_no_fin = vecs[v].no_fin;
      model_run();
      run_seq($sformatf("T%0d", v + 1), (v == 0));
      compare_run($sformatf("T%0d", v + 1));
      chk($sformatf("T%0d_vec_nwrites", v + 1), got_q.size(), vecs[v].exp_nw);
      chk($sformatf("T%0d_vec_done", v + 1), done, vecs[v].exp_done);
      chk($sformatf("T%0d_vec_error", v + 1), error, vecs[v].exp_err);
      chk($sformatf("T%0d_vec_err_idx", v + 1), err_idx, vecs[v].exp_eidx);
      if (v == 0) begin
        // The delay entry (4 units of 5 cycles) adds at least 20 cycles
        // between the idx1 and idx3 writes, plus a few cycles of table walk.
        g = (rise_q.size() >= 3) ? (rise_q[2] - rise_q[1]) - (rise_q[1] - rise_q[0]) : -1;
        chk("T1_delay_gap_20_to_23", (g >= 20 && g <= 23), 1);
      end
      if (v == 3) begin
        chk("T4_timeout_req_len", (len_q.size() > 0) ? len_q[0] : -1, TO);
      end
      repeat (3) @(negedge clk);
    end

    // T5: reset in the middle of a write
    for (int j = 0; j < N; j++) begin
      cur_a[j] = vecs[0].a[j]; cur_d[j] = vecs[0].d[j]; cur_fail[j] = 0;
    end
    cur_no_fin = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    g = 0;
    while (!wr_req && g < 200) begin @(negedge clk); g++; end
    chk("T5_wr_req_seen", wr_req, 1);
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("T5_async_wr_req", wr_req, 0);
    chk("T5_async_busy", busy, 0);
    chk("T5_async_state", state_dbg, 0);
    @(negedge clk); reset_n = 1;
    repeat (2) @(negedge clk);
    model_run();
    run_seq("T5_rerun", 0);
    compare_run("T5_rerun");

`ifdef IIC_VERIFY_EN
    // T6: the first read-back of idx1 returns 0x21, so the write is repeated
    cur_vfail[1] = 1;
    model_run();
    run_seq("T6", 0);
    compare_run("T6");
    cur_vfail[1] = 0;
`endif

    // Randomized tables and failure plans
    for (int t = 0; t < 15; t++) begin
      int r;
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          cur_a[j] = 8'hFF; cur_d[j] = 8'($urandom_range(0, 3));
        end else begin
          cur_a[j] = 8'($urandom_range(0, 254)); cur_d[j] = 8'($urandom_range(0, 255));
        end
        r = $urandom_range(0, 9);
        cur_fail[j] = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
        cur_vfail[j] = 0;
      end
      cur_no_fin = ($urandom_range(0, 3) == 0);
      model_run();
      run_seq($sformatf("R%0d", t), 0);
      compare_run($sformatf("R%0d", t));
      repeat (2) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "global timeout");
  end

endmodule
